// File: rtl/mem_request_queue_pkg.sv
// Shared types for the trace-driven memory request path: time base,
// age counters, request opcodes and the parser-to-queue request record.
package global_defs;

  localparam int QUEUE_SIZE = 16;

  typedef logic [63:0] int_t;
  typedef logic [7:0]  age_counter_t;

  typedef enum logic [1:0] {
    READ   = 2'd0,
    WRITE  = 2'd1,
    IFETCH = 2'd2
  } opcode_t;

  // The timestamp field is req_time because `time` is a reserved word.
  typedef struct packed {
    int_t        req_time;
    opcode_t     opcode;
    logic [32:0] address;
  } parser_out_struct_t;

  typedef enum logic [1:0] {
    PARSER_IDLE,
    PARSER_READ_LINE,
    PARSER_WAIT_DUE,
    PARSER_DONE
  } parser_states_t;

  // Age increment that sticks at the counter's maximum value.
  function automatic age_counter_t age_inc(input age_counter_t a);
    return (a == 8'hFF) ? a : a + 8'd1;
  endfunction

endpackage

// File: rtl/mem_request_queue_entry_shift.sv
// One storage slot of the request queue: loads a new request, shifts in
// its upper neighbour on a retire, clears when it falls out of the valid
// region, and otherwise ages its stored request.
module queue_entry_shift
  import global_defs::*;
(
  input  logic               clk,
  input  logic               rst_n,
  input  logic               i_load,
  input  logic               i_shift,
  input  logic               i_keep,
  input  parser_out_struct_t i_load_data,
  input  parser_out_struct_t i_shift_data,
  input  age_counter_t       i_shift_age,
  output parser_out_struct_t o_data,
  output age_counter_t       o_age
);

  parser_out_struct_t r_data;
  age_counter_t       r_age;

  // Slot update: load wins, then clear, then shift, then plain aging.
  // NOTE: storage is reset as well, because an unused slot must read zero.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_data <= '0;
      r_age  <= '0;
    end else if (i_load) begin
      r_data <= i_load_data;
      r_age  <= '0;
    end else if (!i_keep) begin
      r_data <= '0;
      r_age  <= '0;
    end else if (i_shift) begin
      // NOTE: non-blocking so every slot samples its neighbour's old value.
      r_data <= i_shift_data;
      r_age  <= age_inc(i_shift_age);
    end else begin
      r_age  <= age_inc(r_age);
    end
  end

  assign o_data = r_data;
  assign o_age  = r_age;

endmodule

// File: rtl/mem_request_queue.sv
// Bounded, aging FIFO of memory requests between the trace parser and the
// memory controller. Owns the simulation time base queue_time. The head is
// retired once it has aged SERVICE_CYCLES cycles.
// Optional build macro TIME_SKIP_EN: with an empty queue, queue_time jumps
// straight to a far-future pending request's timestamp.
module mem_request_queue
  import global_defs::int_t;
  import global_defs::age_counter_t;
  import global_defs::parser_out_struct_t;
#(
  parameter int QUEUE_SIZE     = global_defs::QUEUE_SIZE,
  parameter int SERVICE_CYCLES = 100
) (
  input  logic               clk,
  input  logic               rst_n,
  input  parser_out_struct_t in,
  input  logic               pending_request,
  output logic               queue_full,
  output parser_out_struct_t out,
  output logic               out_valid,
  output parser_out_struct_t queue [QUEUE_SIZE],
  output age_counter_t       age [QUEUE_SIZE],
  output int_t               queue_time
);

  localparam int CW = $clog2(QUEUE_SIZE + 1);

  logic [CW-1:0]      r_count;
  int_t               r_time;
  parser_out_struct_t r_out;
  logic               r_out_valid;

  logic               w_push;
  logic               w_pop;
  logic [CW-1:0]      w_count_after_pop;
  logic [QUEUE_SIZE-1:0] w_load;
  logic [QUEUE_SIZE-1:0] w_keep;
  int_t               w_time_next;

  assign queue_full = (r_count == CW'(QUEUE_SIZE));

  // Push is blocked while full even if the head retires this cycle.
  assign w_push = pending_request && !queue_full && (in.req_time <= r_time);
  assign w_pop  = (r_count != '0) && (age[0] == age_counter_t'(SERVICE_CYCLES - 1));
  assign w_count_after_pop = r_count - {{(CW-1){1'b0}}, w_pop};

`ifdef TIME_SKIP_EN
  // Idle queue with a far-future request: jump the clock to its timestamp.
  assign w_time_next = ((r_count == '0) && pending_request && (in.req_time > r_time + 64'd1))
                       ? in.req_time : r_time + 64'd1;
`else
  assign w_time_next = r_time + 64'd1;
`endif

  // Per-slot control: slots below the post-retire count stay valid, and the
  // first free slot after the shift takes the pushed request.
  // NOTE: both vectors get a default first so no latch is inferred.
  always_comb begin
    w_load = '0;
    w_keep = '0;
    for (int i = 0; i < QUEUE_SIZE; i++) begin
      w_keep[i] = (CW'(i) < w_count_after_pop);
      w_load[i] = w_push && (CW'(i) == w_count_after_pop);
    end
  end

  // Storage slots; the top slot shifts in zero.
  for (genvar g = 0; g < QUEUE_SIZE; g++) begin : g_slot
    parser_out_struct_t w_shift_data;
    age_counter_t       w_shift_age;
    if (g < QUEUE_SIZE - 1) begin : g_mid
      assign w_shift_data = queue[g+1];
      assign w_shift_age  = age[g+1];
    end else begin : g_top
      assign w_shift_data = '0;
      assign w_shift_age  = '0;
    end
    queue_entry_shift u_slot (
      .clk          (clk),
      .rst_n        (rst_n),
      .i_load       (w_load[g]),
      .i_shift      (w_pop),
      .i_keep       (w_keep[g]),
      .i_load_data  (in),
      .i_shift_data (w_shift_data),
      .i_shift_age  (w_shift_age),
      .o_data       (queue[g]),
      .o_age        (age[g])
    );
  end

  // Occupancy, time base and retire output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_count     <= '0;
      r_time      <= '0;
      r_out       <= '0;
      r_out_valid <= 1'b0;
    end else begin
      r_count     <= w_count_after_pop + {{(CW-1){1'b0}}, w_push};
      r_time      <= w_time_next;
      r_out_valid <= w_pop;
      if (w_pop) begin
        r_out <= queue[0];
      end
    end
  end

  assign out        = r_out;
  assign out_valid  = r_out_valid;
  assign queue_time = r_time;

endmodule

// File: tb/tb_mem_request_queue.sv
// Self-checking bench for mem_request_queue: random and directed requests,
// a request-level reference model, and a scoreboard of expected retires.
`timescale 1ns/1ps
module tb_mem_request_queue;
  import global_defs::*;

  localparam int QS = global_defs::QUEUE_SIZE;
  localparam int SC = 100;

  logic               clk = 1'b0;
  logic               rst_n = 1'b0;
  parser_out_struct_t in_req;
  logic               pending;
  logic               full;
  parser_out_struct_t out_req;
  logic               out_valid;
  parser_out_struct_t q [QS];
  age_counter_t       a [QS];
  int_t               qtime;

  mem_request_queue #(.QUEUE_SIZE(QS), .SERVICE_CYCLES(SC)) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .in              (in_req),
    .pending_request (pending),
    .queue_full      (full),
    .out             (out_req),
    .out_valid       (out_valid),
    .queue           (q),
    .age             (a),
    .queue_time      (qtime)
  );

  always #5 clk = ~clk;

  typedef struct { parser_out_struct_t req; longint unsigned label; } entry_t;
  typedef struct { parser_out_struct_t req; longint unsigned due;   } expect_t;

  entry_t             mq[$];    // model contents, oldest first
  expect_t            sb[$];    // expected retires, in order
  parser_out_struct_t stim[$];  // requests the parser still has to hand over
  longint unsigned    m_time;
  bit                 m_pop;
  parser_out_struct_t m_out;
  int unsigned        n_vec;
  int unsigned        n_bad;
  bit                 checking;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic parser_out_struct_t mk(input longint unsigned t, input opcode_t op,
                                            input logic [32:0] addr);
    parser_out_struct_t r;
    r.req_time = t;
    r.opcode   = op;
    r.address  = addr;
    return r;
  endfunction

  // Called at a falling edge: present the parser's request and predict what
  // the coming rising edge does, from the queue rules at request level.
  task automatic step();
    bit push, pop, skip;
    pending = (stim.size() > 0);
    in_req  = pending ? stim[0] : '0;
    pop  = (mq.size() > 0) && (mq[0].label + SC == m_time);
    push = pending && (mq.size() < QS) && (in_req.req_time <= m_time);
    skip = 1'b0;
`ifdef TIME_SKIP_EN
    skip = (mq.size() == 0) && pending && (in_req.req_time > m_time + 1);
`endif
    if (pop) begin
      m_out = mq[0].req;
      void'(mq.pop_front());
    end
    if (push) begin
      mq.push_back('{in_req, m_time});
      sb.push_back('{in_req, m_time + SC + 1});
      void'(stim.pop_front());
    end
    m_pop  = pop;
    m_time = skip ? in_req.req_time : m_time + 1;
  endtask

  task automatic run(input int n);
    repeat (n) begin
      @(negedge clk);
      step();
    end
  endtask

  task automatic reset_checks();
    check("rst_queue_time", qtime, 0);
    check("rst_queue_full", full, 0);
    check("rst_out_valid", out_valid, 0);
    check("rst_out", out_req, 0);
    for (int i = 0; i < QS; i++) begin
      check($sformatf("rst_queue[%0d]", i), q[i], 0);
      check($sformatf("rst_age[%0d]", i), a[i], 0);
    end
  endtask

  task automatic release_reset();
    @(negedge clk);
    rst_n    = 1'b1;
    checking = 1'b1;
    step();
  endtask

  // Mid-operation reset: everything clears at once and nothing retires.
  task automatic do_reset();
    @(negedge clk);
    rst_n    = 1'b0;
    checking = 1'b0;
    #1 reset_checks();
    mq.delete();
    sb.delete();
    stim.delete();
    m_time  = 0;
    m_pop   = 1'b0;
    m_out   = '0;
    pending = 1'b0;
    in_req  = '0;
    repeat (3) @(posedge clk);
    #1 reset_checks();
    release_reset();
  endtask

  // Monitor: compare visible state every cycle and retire against the scoreboard.
  always @(posedge clk) begin
    #1;
    if (checking) begin
      check("queue_time", qtime, m_time);
      check("queue_full", full, mq.size() == QS);
      check("out_valid", out_valid, m_pop);
      check("out_hold", out_req, m_out);
      for (int i = 0; i < QS; i++) begin
        parser_out_struct_t er;
        longint unsigned    ea;
        er = '0;
        ea = 0;
        if (i < mq.size()) begin
          er = mq[i].req;
          ea = m_time - 1 - mq[i].label;
          if (ea > 255) ea = 255;
        end
        check($sformatf("queue[%0d]", i), q[i], er);
        check($sformatf("age[%0d]", i), a[i], ea);
      end
      if (out_valid) begin
        check("retire_expected", sb.size() != 0, 1);
        if (sb.size() != 0) begin
          expect_t e;
          e = sb.pop_front();
          check("retire_req", out_req, e.req);
          check("retire_time", qtime, e.due);
        end
      end
    end
  end

  initial begin
    bit found;
    checking = 1'b0;
    pending  = 1'b0;
    in_req   = '0;
    m_time   = 0;
    m_pop    = 1'b0;
    m_out    = '0;
    n_vec    = 0;
    n_bad    = 0;

    // Reset held for 10 clocks, with a request already waiting.
    stim.push_back(mk(2, READ, 33'h1_0000_0040));
    repeat (10) @(posedge clk);
    #1 reset_checks();
    release_reset();
    run(115);

    // Ordering: three due requests retire on consecutive cycles.
    stim.push_back(mk(0, READ,   33'h0_0000_1000));
    stim.push_back(mk(1, WRITE,  33'h0_0000_2000));
    stim.push_back(mk(2, IFETCH, 33'h1_0000_3000));
    run(110);

    // Fill: 17 requests; the last waits for the first retire plus one cycle.
    for (int i = 0; i < 17; i++)
      stim.push_back(mk(0, opcode_t'(i % 3), 33'(i * 64)));
    run(240);

    // Push coinciding with a retire while five entries are stored.
    for (int i = 0; i < 5; i++)
      stim.push_back(mk(0, WRITE, 33'(32'h4000 + i)));
    found = 1'b0;
    for (int k = 0; k < 300 && !found; k++) begin
      if (mq.size() == 5 && mq[0].label + SC == m_time) found = 1'b1;
      else run(1);
    end
    check("pushpop_reached", found, 1);
    stim.push_back(mk(0, IFETCH, 33'h1_DEAD_BEEF));
    run(1);
    run(120);

    // Randomized traffic, near and slightly-future timestamps.
    for (int c = 0; c < 1500; c++) begin
      if (stim.size() < 4 && $urandom_range(0, 4) == 0) begin
        longint unsigned t;
        t = m_time + $urandom_range(0, 5);
        t = (t >= 3) ? t - $urandom_range(0, 3) : t;
        stim.push_back(mk(t, opcode_t'($urandom_range(0, 2)),
                          {1'($urandom), 32'($urandom)}));
      end
      run(1);
    end

    // Reset while busy, then a far-future request on an empty queue.
    do_reset();
    run(9);
    stim.push_back(mk(1000, READ, 33'h0_1234_5678));
    run(1110);

    // Drain everything still outstanding.
    for (int k = 0; k < 2000 && (mq.size() != 0 || stim.size() != 0); k++)
      run(1);
    run(2);
    check("scoreboard_empty", sb.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/mem_request_queue.md
Name: mem_request_queue

Overview:
- Bounded FIFO of memory requests between the trace parser (upstream) and the memory controller (downstream).
- Owns the simulation time base `queue_time`, which the parser uses to decide when a trace line is due.
- Accepts one request per cycle from the parser and holds up to QUEUE_SIZE entries, each with an age counter.
- Retires the oldest entry once it has aged SERVICE_CYCLES.

Parameters:
- QUEUE_SIZE, default 16 (global_defs::QUEUE_SIZE): maximum number of stored requests.
- SERVICE_CYCLES, default 100: age at which the head entry is retired; legal range 1..255.

Ports:
- clk  in  1  clock; one cycle = one CPU clock.
- rst_n  in  1  asynchronous active-low reset.
- in  in  parser_out_struct_t  request currently held by the parser (time, opcode, address).
- pending_request  in  1  parser holds an unconsumed request on `in`.
- queue_full  out  1  count == QUEUE_SIZE.
- out  out  parser_out_struct_t  most recently retired request.
- out_valid  out  1  one-cycle pulse: `out` was updated this cycle.
- queue  out  parser_out_struct_t [QUEUE_SIZE]  stored entries; index 0 = oldest.
- age  out  age_counter_t [QUEUE_SIZE]  age of each stored entry, same indexing.
- queue_time  out  int_t  current simulation time in CPU clocks.

Behaviour:
- Reset (async, rst_n=0):
  - queue_time=0, count=0, queue_full=0, out_valid=0.
  - out, all queue[i] and all age[i] = 0.
- Time base: queue_time increments by 1 every rising clk edge.
- Push condition, evaluated at the edge: pending_request && !queue_full && in.time <= queue_time.
  - Entry is written at index count (after any pop shift in the same cycle) with age 0.
  - The parser sees the accept as `in.time <= queue_time && !queue_full` and drops pending_request on the next edge.
- Aging: every valid entry's age increments by 1 per cycle, saturating at 255.
- Pop condition: count>0 && age[0] == SERVICE_CYCLES-1 at the edge.
  - out <= queue[0]; out_valid <= 1.
  - Entries shift down one index; vacated slot is zeroed.
  - Net effect: a request spends exactly SERVICE_CYCLES cycles in the queue.
- out_valid is 0 on every cycle with no pop; `out` holds its last value.
- Simultaneous push and pop:
  - Both occur; count is unchanged.
  - The pushed entry lands at index count-1.
- Full: push is blocked whenever queue_full=1 at the edge, even if a pop occurs in the same cycle (no bypass). Push resumes the following cycle.
- Empty: no pop; out_valid=0.
- Invalid slots (index >= count) always read as all-zero in both `queue` and `age`.
- queue_full is combinational from the count register.
- Reset asserted mid-operation immediately clears all state; no request is retired.

Optional Feature:
- Macro TIME_SKIP_EN.
- When defined: if count==0 and pending_request and in.time > queue_time+1, queue_time loads in.time instead of incrementing. The push then happens on the following edge.
- When undefined: queue_time always increments by 1.

Decomposition:
- global_defs package holds:
  - int_t (64-bit unsigned), age_counter_t (8-bit unsigned).
  - opcode_t (2-bit enum: READ=0, WRITE=1, IFETCH=2).
  - parser_out_struct_t {int_t time; opcode_t opcode; logic [32:0] address}.
  - QUEUE_SIZE=16, parser_states_t.
- Optional sub-module queue_entry_shift: a single storage slot with shift-in, load and age logic, replicated QUEUE_SIZE times.
- Top level contains the count, time and control logic.

Test Plan:
- Reset: hold rst_n=0 for 10 ticks → queue_time=0, count=0, queue_full=0, out_valid=0, all age/queue zero. After release, queue_time=5 after 5 clocks.
- Single request {time=2, READ, 0x1_0000_0040} pending from reset:
  - Pushed at the edge where queue_time becomes 2→3, with age[0]=0.
  - Popped 100 cycles later: out_valid pulses once; out matches the request.
- Ordering: 3 requests at times 0,1,2 → retired on consecutive cycles in order 0,1,2; age[0..2] differ by 1 while stored.
- Fill: 17 requests all at time 0 → queue_full=1 after 16 pushes. The 17th stays pending until the first pop, and is accepted one cycle after the pop cycle.
- Simultaneous push/pop while count=5 → count stays 5; new entry at index 4; queue[5] remains zero.
- TIME_SKIP_EN: queue empty, request time=1000 pending at queue_time=10:
  - Defined: queue_time=1000 next cycle; push the cycle after.
  - Undefined: push occurs at queue_time 1000 after 990 cycles.
